bp_initiator: RTL and testbench

BP_INITIATOR -- requirements
Module: bpInitiator

---
 rtl/bp_initiator.sv | 145 ++++++++++++++
 tb/tb_bp_initiator.sv | 297 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/bp_initiator.sv
// BytePipe initiator: turns host register requests into a command byte (plus a data byte
// for writes), then waits for one response byte or a timeout and hands the result back.
module bp_initiator #(
  parameter int TIMEOUT = 255
) (
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic       i_cg,
  input  logic       i_req_valid,
  output logic       o_req_ready,
  input  logic       i_req_wr,
  input  logic [6:0] i_req_addr,
  input  logic [7:0] i_req_data,
  output logic [7:0] o_bp_data,
  output logic       o_bp_valid,
  input  logic       i_bp_ready,
  input  logic [7:0] i_bp_data,
  input  logic       i_bp_valid,
  output logic       o_bp_ready,
  output logic [7:0] o_rsp_data,
  output logic       o_rsp_valid,
  input  logic       i_rsp_ready,
  output logic       o_rsp_timeout,
  output logic [7:0] o_strayCount
);

  localparam int CW = $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] CNT_MAX = CW'(TIMEOUT);

  typedef enum logic [2:0] {
    IDLE,
    SEND_CMD,
    SEND_DATA,
    WAIT_RSP,
    HOLD_RSP
  } state_t;

  state_t state;
  state_t state_nxt;

  logic          req_wr;
  logic [6:0]    req_addr;
  logic [7:0]    req_data;
  logic [CW-1:0] cnt;
  logic [7:0]    rsp_data;
  logic          rsp_timeout;
  logic [7:0]    stray_cnt;
  logic          timed_out;

  assign timed_out = (cnt == CNT_MAX);

  // Outputs depend only on state and i_cg, so o_req_ready never sees i_rsp_ready.
  always_comb begin
    state_nxt   = state;
    o_req_ready = 1'b0;
    o_bp_valid  = 1'b0;
    o_bp_data   = 8'h00;
    o_bp_ready  = 1'b0;
    o_rsp_valid = 1'b0;
    case (state)
      IDLE: begin
        o_req_ready = i_cg;
        o_bp_ready  = i_cg;
        if (i_cg && i_req_valid) state_nxt = SEND_CMD;
      end
      SEND_CMD: begin
        o_bp_valid = 1'b1;
        o_bp_data  = {req_wr, req_addr};
        if (i_cg && i_bp_ready) state_nxt = req_wr ? SEND_DATA : WAIT_RSP;
      end
      SEND_DATA: begin
        o_bp_valid = 1'b1;
        o_bp_data  = req_data;
        if (i_cg && i_bp_ready) state_nxt = WAIT_RSP;
      end
      WAIT_RSP: begin
        o_bp_ready = i_cg;
        if (i_cg && (i_bp_valid || timed_out)) state_nxt = HOLD_RSP;
      end
      HOLD_RSP: begin
        o_rsp_valid = 1'b1;
        if (i_cg && i_rsp_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state <= IDLE;
    end else if (i_cg) begin
      state <= state_nxt;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      req_wr   <= 1'b0;
      req_addr <= 7'h00;
      req_data <= 8'h00;
    end else if (i_cg && state == IDLE && i_req_valid) begin
      req_wr   <= i_req_wr;
      req_addr <= i_req_addr;
      req_data <= i_req_data;
    end
  end

  // Counter only advances while staying in WAIT_RSP, so it stops at CNT_MAX and never wraps.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      cnt <= '0;
    end else if (i_cg) begin
      if (state != WAIT_RSP && state_nxt == WAIT_RSP) cnt <= '0;
      else if (state == WAIT_RSP && state_nxt == WAIT_RSP) cnt <= cnt + CW'(1);
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      rsp_data    <= 8'h00;
      rsp_timeout <= 1'b0;
    end else if (i_cg && state == WAIT_RSP) begin
      if (i_bp_valid) begin
        rsp_data    <= i_bp_data;
        rsp_timeout <= 1'b0;
      end else if (timed_out) begin
        rsp_data    <= 8'h00;
        rsp_timeout <= 1'b1;
      end
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      stray_cnt <= 8'h00;
    end else if (i_cg && state == IDLE && i_bp_valid && stray_cnt != 8'hFF) begin
      stray_cnt <= stray_cnt + 8'd1;
    end
  end

  assign o_rsp_data    = rsp_data;
  assign o_rsp_timeout = rsp_timeout;
  assign o_strayCount  = stray_cnt;

endmodule

// File: tb/tb_bp_initiator.sv
// Self-checking bench for bp_initiator: cycle-by-cycle vector table for basic read/write
// traffic, then hand-written sequences for timeout, clock gating, reset and stray bytes.
module tb_bp_initiator;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       cg;
  logic       req_valid;
  logic       req_ready;
  logic       req_wr;
  logic [6:0] req_addr;
  logic [7:0] req_data;
  logic [7:0] bp_data_out;
  logic       bp_valid_out;
  logic       bp_ready_in;
  logic [7:0] bp_data_in;
  logic       bp_valid_in;
  logic       bp_ready_out;
  logic [7:0] rsp_data;
  logic       rsp_valid;
  logic       rsp_ready;
  logic       rsp_timeout;
  logic [7:0] stray_count;

  int checks = 0;
  int errors = 0;

  bp_initiator #(.TIMEOUT(4)) dut (
    .i_clk         (clk),
    .i_rst_n       (rst_n),
    .i_cg          (cg),
    .i_req_valid   (req_valid),
    .o_req_ready   (req_ready),
    .i_req_wr      (req_wr),
    .i_req_addr    (req_addr),
    .i_req_data    (req_data),
    .o_bp_data     (bp_data_out),
    .o_bp_valid    (bp_valid_out),
    .i_bp_ready    (bp_ready_in),
    .i_bp_data     (bp_data_in),
    .i_bp_valid    (bp_valid_in),
    .o_bp_ready    (bp_ready_out),
    .o_rsp_data    (rsp_data),
    .o_rsp_valid   (rsp_valid),
    .i_rsp_ready   (rsp_ready),
    .o_rsp_timeout (rsp_timeout),
    .o_strayCount  (stray_count)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish, got timeout required completion");
    $fatal(1, "[TB] watchdog expired");
  end

  typedef struct {
    logic       cg;
    logic       req_valid;
    logic       req_wr;
    logic [6:0] req_addr;
    logic [7:0] req_data;
    logic       bp_ready;
    logic       bp_valid;
    logic [7:0] bp_in;
    logic       rsp_ready;
    logic       x_req_ready;
    logic       x_bp_valid;
    logic [7:0] x_bp_data;
    logic       x_bp_ready;
    logic       x_rsp_valid;
    logic [7:0] x_rsp_data;
    logic       x_rsp_timeout;
    logic [7:0] x_stray;
  } vec_t;

  vec_t vecs[$];

  task automatic check_byte(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %02h expected %02h", name, act, exp);
    end
  endtask

  task automatic check_int(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic apply_stimulus(input vec_t v);
    cg          = v.cg;
    req_valid   = v.req_valid;
    req_wr      = v.req_wr;
    req_addr    = v.req_addr;
    req_data    = v.req_data;
    bp_ready_in = v.bp_ready;
    bp_valid_in = v.bp_valid;
    bp_data_in  = v.bp_in;
    rsp_ready   = v.rsp_ready;
  endtask

  task automatic check_output(input int idx, input vec_t v);
    check_byte($sformatf("row%0d req_ready", idx), {7'b0, req_ready}, {7'b0, v.x_req_ready});
    check_byte($sformatf("row%0d bp_valid", idx), {7'b0, bp_valid_out}, {7'b0, v.x_bp_valid});
    check_byte($sformatf("row%0d bp_data", idx), bp_data_out, v.x_bp_data);
    check_byte($sformatf("row%0d bp_ready", idx), {7'b0, bp_ready_out}, {7'b0, v.x_bp_ready});
    check_byte($sformatf("row%0d rsp_valid", idx), {7'b0, rsp_valid}, {7'b0, v.x_rsp_valid});
    if (v.x_rsp_valid) begin
      check_byte($sformatf("row%0d rsp_data", idx), rsp_data, v.x_rsp_data);
      check_byte($sformatf("row%0d rsp_timeout", idx), {7'b0, rsp_timeout}, {7'b0, v.x_rsp_timeout});
    end
    check_byte($sformatf("row%0d stray", idx), stray_count, v.x_stray);
  endtask

  // Leaves the caller at the falling edge of the first WAIT_RSP cycle.
  task automatic issue_req(input logic wr, input logic [6:0] addr, input logic [7:0] data);
    @(negedge clk);
    req_valid = 1'b1;
    req_wr    = wr;
    req_addr  = addr;
    req_data  = data;
    #1 check_byte("issue req_ready", {7'b0, req_ready}, 8'h01);
    @(negedge clk);
    req_valid   = 1'b0;
    bp_ready_in = 1'b1;
    #1 check_byte("issue cmd byte", bp_data_out, {wr, addr});
    if (wr) begin
      @(negedge clk);
      #1 check_byte("issue data byte", bp_data_out, data);
    end
    @(negedge clk);
    bp_ready_in = 1'b0;
  endtask

  task automatic finish_rsp(input string name, input logic [7:0] exp_data, input logic exp_to);
    #1;
    check_byte({name, " rsp_valid"}, {7'b0, rsp_valid}, 8'h01);
    check_byte({name, " rsp_data"}, rsp_data, exp_data);
    check_byte({name, " rsp_timeout"}, {7'b0, rsp_timeout}, {7'b0, exp_to});
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
    #1 check_byte({name, " back to idle"}, {7'b0, rsp_valid}, 8'h00);
  endtask

  task automatic wait_hold(output int n);
    n = 0;
    #1;
    while (!rsp_valid && n < 20) begin
      @(negedge clk);
      #1;
      n++;
    end
  endtask

  initial begin
    int n;
    int bad;
    // cg rv wr addr data | bpr bpv bpin rspr || xrr xbv xbd xbr xrv xrd xto xst
    vecs.push_back('{1'b1,1'b0,1'b0,7'h00,8'h00, 1'b0,1'b1,8'h77,1'b0, 1'b1,1'b0,8'h00,1'b1,1'b0,8'h00,1'b0,8'h00});
    vecs.push_back('{1'b0,1'b1,1'b0,7'h05,8'h00, 1'b0,1'b1,8'h77,1'b0, 1'b0,1'b0,8'h00,1'b0,1'b0,8'h00,1'b0,8'h01});
    vecs.push_back('{1'b1,1'b0,1'b0,7'h00,8'h00, 1'b0,1'b0,8'h00,1'b0, 1'b1,1'b0,8'h00,1'b1,1'b0,8'h00,1'b0,8'h01});
    vecs.push_back('{1'b1,1'b1,1'b0,7'h05,8'h00, 1'b0,1'b0,8'h00,1'b0, 1'b1,1'b0,8'h00,1'b1,1'b0,8'h00,1'b0,8'h01});
    vecs.push_back('{1'b1,1'b0,1'b0,7'h00,8'h00, 1'b1,1'b0,8'h00,1'b0, 1'b0,1'b1,8'h05,1'b0,1'b0,8'h00,1'b0,8'h01});
    vecs.push_back('{1'b1,1'b0,1'b0,7'h00,8'h00, 1'b0,1'b0,8'h00,1'b0, 1'b0,1'b0,8'h00,1'b1,1'b0,8'h00,1'b0,8'h01});
    vecs.push_back('{1'b1,1'b0,1'b0,7'h00,8'h00, 1'b0,1'b0,8'h00,1'b0, 1'b0,1'b0,8'h00,1'b1,1'b0,8'h00,1'b0,8'h01});
    vecs.push_back('{1'b1,1'b0,1'b0,7'h00,8'h00, 1'b0,1'b1,8'h3C,1'b0, 1'b0,1'b0,8'h00,1'b1,1'b0,8'h00,1'b0,8'h01});
    vecs.push_back('{1'b1,1'b0,1'b0,7'h00,8'h00, 1'b0,1'b0,8'h00,1'b0, 1'b0,1'b0,8'h00,1'b0,1'b1,8'h3C,1'b0,8'h01});
    vecs.push_back('{1'b1,1'b1,1'b1,7'h10,8'hA5, 1'b0,1'b0,8'h00,1'b1, 1'b0,1'b0,8'h00,1'b0,1'b1,8'h3C,1'b0,8'h01});
    vecs.push_back('{1'b1,1'b1,1'b1,7'h10,8'hA5, 1'b0,1'b0,8'h00,1'b0, 1'b1,1'b0,8'h00,1'b1,1'b0,8'h00,1'b0,8'h01});
    vecs.push_back('{1'b1,1'b0,1'b0,7'h00,8'h00, 1'b0,1'b0,8'h00,1'b0, 1'b0,1'b1,8'h90,1'b0,1'b0,8'h00,1'b0,8'h01});
    vecs.push_back('{1'b1,1'b0,1'b0,7'h00,8'h00, 1'b0,1'b0,8'h00,1'b0, 1'b0,1'b1,8'h90,1'b0,1'b0,8'h00,1'b0,8'h01});
    vecs.push_back('{1'b1,1'b0,1'b0,7'h00,8'h00, 1'b0,1'b0,8'h00,1'b0, 1'b0,1'b1,8'h90,1'b0,1'b0,8'h00,1'b0,8'h01});
    vecs.push_back('{1'b1,1'b0,1'b0,7'h00,8'h00, 1'b1,1'b0,8'h00,1'b0, 1'b0,1'b1,8'h90,1'b0,1'b0,8'h00,1'b0,8'h01});
    vecs.push_back('{1'b0,1'b0,1'b0,7'h00,8'h00, 1'b1,1'b0,8'h00,1'b0, 1'b0,1'b1,8'hA5,1'b0,1'b0,8'h00,1'b0,8'h01});
    vecs.push_back('{1'b1,1'b0,1'b0,7'h00,8'h00, 1'b1,1'b0,8'h00,1'b0, 1'b0,1'b1,8'hA5,1'b0,1'b0,8'h00,1'b0,8'h01});
    vecs.push_back('{1'b1,1'b0,1'b0,7'h00,8'h00, 1'b0,1'b1,8'h5A,1'b0, 1'b0,1'b0,8'h00,1'b1,1'b0,8'h00,1'b0,8'h01});
    vecs.push_back('{1'b1,1'b0,1'b0,7'h00,8'h00, 1'b0,1'b0,8'h00,1'b1, 1'b0,1'b0,8'h00,1'b0,1'b1,8'h5A,1'b0,8'h01});
    vecs.push_back('{1'b1,1'b0,1'b0,7'h00,8'h00, 1'b0,1'b0,8'h00,1'b0, 1'b1,1'b0,8'h00,1'b1,1'b0,8'h00,1'b0,8'h01});

    rst_n       = 1'b0;
    cg          = 1'b1;
    req_valid   = 1'b0;
    req_wr      = 1'b0;
    req_addr    = 7'h00;
    req_data    = 8'h00;
    bp_ready_in = 1'b0;
    bp_data_in  = 8'h00;
    bp_valid_in = 1'b0;
    rsp_ready   = 1'b0;
    #1;
    check_byte("reset bp_valid", {7'b0, bp_valid_out}, 8'h00);
    check_byte("reset bp_data", bp_data_out, 8'h00);
    check_byte("reset rsp_valid", {7'b0, rsp_valid}, 8'h00);
    check_byte("reset rsp_data", rsp_data, 8'h00);
    check_byte("reset rsp_timeout", {7'b0, rsp_timeout}, 8'h00);
    check_byte("reset stray", stray_count, 8'h00);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < vecs.size(); i++) begin
      @(negedge clk);
      apply_stimulus(vecs[i]);
      #1 check_output(i, vecs[i]);
    end
    apply_stimulus('{1'b1,1'b0,1'b0,7'h00,8'h00, 1'b0,1'b0,8'h00,1'b0, 1'b0,1'b0,8'h00,1'b0,1'b0,8'h00,1'b0,8'h00});

    $display("[TB] timeout with silent responder");
    issue_req(1'b0, 7'h33, 8'h00);
    wait_hold(n);
    check_int("timeout latency", n, 5);
    finish_rsp("timeout", 8'h00, 1'b1);

    $display("[TB] byte on the last wait cycle");
    issue_req(1'b0, 7'h34, 8'h00);
    repeat (4) @(negedge clk);
    #1 check_byte("late byte no early hold", {7'b0, rsp_valid}, 8'h00);
    bp_valid_in = 1'b1;
    bp_data_in  = 8'hC3;
    @(negedge clk);
    bp_valid_in = 1'b0;
    finish_rsp("late byte", 8'hC3, 1'b0);

    $display("[TB] clock gate freeze in wait");
    issue_req(1'b0, 7'h11, 8'h00);
    repeat (2) @(negedge clk);
    cg          = 1'b0;
    bp_valid_in = 1'b1;
    bp_data_in  = 8'hEE;
    bad = 0;
    for (int i = 0; i < 10; i++) begin
      #1 if (bp_ready_out || rsp_valid) bad++;
      @(negedge clk);
    end
    check_int("gated cycles accepting", bad, 0);
    cg          = 1'b1;
    bp_valid_in = 1'b0;
    wait_hold(n);
    check_int("resume latency", n, 3);
    finish_rsp("resume", 8'h00, 1'b1);

    $display("[TB] reset during data byte");
    @(negedge clk);
    req_valid = 1'b1;
    req_wr    = 1'b1;
    req_addr  = 7'h22;
    req_data  = 8'h6B;
    @(negedge clk);
    req_valid   = 1'b0;
    bp_ready_in = 1'b1;
    @(negedge clk);
    bp_ready_in = 1'b0;
    #1 check_byte("pre-reset data byte", bp_data_out, 8'h6B);
    #1 rst_n = 1'b0;
    #1;
    check_byte("midreset bp_valid", {7'b0, bp_valid_out}, 8'h00);
    check_byte("midreset bp_data", bp_data_out, 8'h00);
    check_byte("midreset rsp_valid", {7'b0, rsp_valid}, 8'h00);
    check_byte("midreset rsp_data", rsp_data, 8'h00);
    check_byte("midreset rsp_timeout", {7'b0, rsp_timeout}, 8'h00);
    check_byte("midreset stray", stray_count, 8'h00);
    @(negedge clk);
    rst_n = 1'b1;
    #1 check_byte("post-reset req_ready", {7'b0, req_ready}, 8'h01);
    check_byte("post-reset rsp_valid", {7'b0, rsp_valid}, 8'h00);
    issue_req(1'b0, 7'h07, 8'h00);
    bp_valid_in = 1'b1;
    bp_data_in  = 8'h81;
    @(negedge clk);
    bp_valid_in = 1'b0;
    finish_rsp("post-reset read", 8'h81, 1'b0);

    $display("[TB] stray byte saturation");
    @(negedge clk);
    bp_valid_in = 1'b1;
    bp_data_in  = 8'h99;
    bad = 0;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      #1 if (rsp_valid) bad++;
    end
    bp_valid_in = 1'b0;
    @(negedge clk);
    #1 check_byte("stray saturated", stray_count, 8'hFF);
    check_int("stray rsp_valid cycles", bad, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
